// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB).
//   cdb_pkt_t : writeback payload broadcast on the CDB
//   CDB_*     : requester indices (MUL, LOAD, CMP, ALU)
package cdb_types;

  localparam int N_REQ     = 4;
  localparam int PTR_W     = $clog2(N_REQ);
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PHYS_REGS = 64;
  localparam int PD_W      = $clog2(PHYS_REGS);
  localparam int ARCH_W    = 5;

  localparam int CDB_MUL  = 0;
  localparam int CDB_LOAD = 1;
  localparam int CDB_CMP  = 2;
  localparam int CDB_ALU  = 3;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PD_W-1:0]      pd;
    logic [ARCH_W-1:0]    rd_arch;
    logic [31:0]          data;
    logic                 regf_we;
    logic                 br_taken;
    logic [31:0]          br_target;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping modulo N.
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot grant (zero when req is zero)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                         req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                         gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_gnt;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (PW'(i) >= ptr);
    end
  end

  // Lower half holds only requests at/above ptr, upper half the full vector,
  // so the lowest set bit of the doubled vector is the wrapped winner.
  assign dbl     = {req, req & mask};
  assign dbl_gnt = dbl & (~dbl + ONE);
  assign gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one execute-unit writeback per cycle (combinational
// grant) and registers the winner for broadcast on the next cycle.
// Optional macro CDB_AGE_PRIO_EN: grant the oldest request relative to
// rob_head instead of round-robin (rr_ptr is still maintained).
//   clk, rst_n : clock, async active-low reset
//   flush      : kills this cycle's grant
//   rob_head   : oldest ROB index (age build only)
//   fu_valid   : request per unit;  fu_pkt : payload per unit
//   fu_ready   : one-hot grant
//   cdb_valid / cdb_pkt / cdb_src : registered broadcast
module cdb_arbiter
  import cdb_types::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [ROB_IDX_W-1:0]         rob_head,
  input  logic [N_REQ-1:0]             fu_valid,
  input  cdb_pkt_t [N_REQ-1:0]         fu_pkt,
  output logic [N_REQ-1:0]             fu_ready,
  output logic                         cdb_valid,
  output cdb_pkt_t                     cdb_pkt,
  output logic [N_REQ-1:0]             cdb_src
);

  logic [PTR_W-1:0] rr_ptr;
  logic [N_REQ-1:0] rr_gnt;
  logic [N_REQ-1:0] sel_gnt;
  cdb_pkt_t         win_pkt;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] nxt_ptr;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (fu_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

`ifdef CDB_AGE_PRIO_EN
  logic [ROB_IDX_W-1:0] age;
  logic [ROB_IDX_W-1:0] best_age;
  logic [PTR_W-1:0]     best_idx;
  logic                 found;
  logic                 unused_rr;

  always_comb begin
    age      = '0;
    best_age = '1;
    best_idx = '0;
    found    = 1'b0;
    sel_gnt  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (fu_valid[i]) begin
        age = fu_pkt[i].rob_idx - rob_head;
        if (!found || age < best_age) begin
          best_age = age;
          best_idx = PTR_W'(i);
          found    = 1'b1;
        end
      end
    end
    if (found) sel_gnt[best_idx] = 1'b1;
  end

  assign unused_rr = ^rr_gnt;
`else
  logic unused_rob_head;

  assign sel_gnt         = rr_gnt;
  assign unused_rob_head = ^rob_head;
`endif

  assign fu_ready = (flush || !rst_n) ? '0 : sel_gnt;

  always_comb begin
    win_pkt = '0;
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (fu_ready[i]) begin
        win_pkt = fu_pkt[i];
        win_idx = PTR_W'(i);
      end
    end
  end

  assign nxt_ptr = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_pkt   <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_valid <= |fu_ready;
      if (|fu_ready) begin
        cdb_pkt <= win_pkt;
        cdb_src <= fu_ready;
        rr_ptr  <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_types::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [ROB_IDX_W-1:0] rob_head = '0;
  logic [N_REQ-1:0]     fu_valid = '0;
  cdb_pkt_t [N_REQ-1:0] fu_pkt = '0;
  logic [N_REQ-1:0]     fu_ready;
  logic                 cdb_valid;
  cdb_pkt_t             cdb_pkt;
  logic [N_REQ-1:0]     cdb_src;

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rob_head  (rob_head),
    .fu_valid  (fu_valid),
    .fu_pkt    (fu_pkt),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    cdb_pkt_t    p;
    logic [3:0]  s;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       errors = 0;
  int       m_ptr  = 0;
  cdb_pkt_t m_pkt  = '0;
  logic [3:0] m_src = '0;
  cdb_pkt_t cust_pkt [N_REQ];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic cdb_pkt_t rand_pkt(input logic [ROB_IDX_W-1:0] rob);
    cdb_pkt_t p;
    p.rob_idx   = rob;
    p.pd        = PD_W'($urandom);
    p.rd_arch   = ARCH_W'($urandom);
    p.data      = $urandom;
    p.regf_we   = 1'($urandom);
    p.br_taken  = 1'($urandom);
    p.br_target = $urandom;
    return p;
  endfunction

  // Reference winner: oldest by ROB distance (age build) or the first valid
  // requester walking from the pointer around the ring.
  function automatic int model_winner(input logic [3:0] v, input logic fl);
    int best = -1;
    int best_age = 1000;
    if (fl) return -1;
`ifdef CDB_AGE_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) begin
        int a = (int'(fu_pkt[i].rob_idx) - int'(rob_head) + ROB_DEPTH) % ROB_DEPTH;
        if (a < best_age) begin
          best_age = a;
          best = i;
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      int j = (m_ptr + k) % N_REQ;
      if (v[j] && best < 0) best = j;
    end
`endif
    return best;
  endfunction

  task automatic step(input logic [3:0] v, input logic fl, input bit custom);
    int w;
    int s;
    int r;
    exp_t e;
    logic [3:0] exp_gnt;
    @(negedge clk);
    rst_n    = 1'b1;
    fu_valid = v;
    flush    = fl;
    s = 2 * $urandom_range(0, 3) + 1;
    r = $urandom_range(0, 15);
    for (int i = 0; i < N_REQ; i++) begin
      if (custom) fu_pkt[i] = cust_pkt[i];
      else fu_pkt[i] = rand_pkt(ROB_IDX_W'(r + i * s));
    end
    if (!custom) rob_head = ROB_IDX_W'($urandom);
    #1;
    w = model_winner(v, fl);
    exp_gnt = (w >= 0) ? 4'(1 << w) : 4'b0;
    chk("grant", 128'(fu_ready), 128'(exp_gnt));
    if (w >= 0) begin
      m_pkt = fu_pkt[w];
      m_src = exp_gnt;
      m_ptr = (w + 1) % N_REQ;
    end
    e.v = (w >= 0);
    e.p = m_pkt;
    e.s = m_src;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    fu_valid = 4'b1111;
    flush    = 1'b0;
    #1;
    chk("reset_ready", 128'(fu_ready), 128'(0));
    chk("reset_valid", 128'(cdb_valid), 128'(0));
    chk("reset_src", 128'(cdb_src), 128'(0));
    chk("reset_pkt", 128'(cdb_pkt), 128'(0));
    sb.delete();
    m_ptr = 0;
    m_pkt = '0;
    m_src = '0;
    @(negedge clk);
    #1;
    chk("reset_hold_ready", 128'(fu_ready), 128'(0));
  endtask

  // Monitor: compares each registered broadcast against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("cdb_valid_in_reset", 128'(cdb_valid), 128'(0));
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cdb_valid", 128'(cdb_valid), 128'(e.v));
        chk("cdb_pkt", 128'(cdb_pkt), 128'(e.p));
        chk("cdb_src", 128'(cdb_src), 128'(e.s));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // first grant after reset goes to idx0
    step(4'b1111, 1'b0, 1'b0);
`ifndef CDB_AGE_PRIO_EN
    chk("first_grant", 128'(fu_ready), 128'(4'b0001));
`endif
    // fairness
    for (int i = 0; i < 7; i++) step(4'b1111, 1'b0, 1'b0);

    // wrap from idx3 back to idx0
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
`ifndef CDB_AGE_PRIO_EN
    chk("wrap_idx3", 128'(fu_ready), 128'(4'b1000));
`endif
    step(4'b1001, 1'b0, 1'b0);
`ifndef CDB_AGE_PRIO_EN
    chk("wrap_idx0", 128'(fu_ready), 128'(4'b0001));
`endif

    // flush then retry
    step(4'b0100, 1'b1, 1'b0);
    chk("flush_ready", 128'(fu_ready), 128'(0));
    step(4'b0100, 1'b0, 1'b0);
    chk("after_flush", 128'(fu_ready), 128'(4'b0100));

    // idle
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);

`ifdef CDB_AGE_PRIO_EN
    for (int i = 0; i < N_REQ; i++) cust_pkt[i] = rand_pkt(ROB_IDX_W'(5 + i));
    cust_pkt[CDB_MUL].rob_idx = 4'd2;
    cust_pkt[CDB_ALU].rob_idx = 4'd15;
    rob_head = 4'd14;
    step(4'b1001, 1'b0, 1'b1);
    chk("age_alu", 128'(fu_ready), 128'(4'b1000));
`endif

    // random traffic with sporadic flushes and mid-stream resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
